// File: rtl/rvx_input_debouncer_pkg.sv
// Shared constants and helpers for the rvx_input_debouncer block.
// Holds the counter-width helper, default timing constants and the
// parameter-legality predicate used at elaboration time.
package rvx_input_debouncer_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 120000;
  localparam int DEFAULT_SYNC_STAGES       = 2;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 1200000;

  // Width needed to hold every value in 0..value inclusive.
  function automatic int counter_width(input int value);
    return (value < 1) ? 1 : $clog2(value + 1);
  endfunction

  // Legal ranges: at least one stable cycle, a real two-flop synchroniser,
  // and a non-zero hold time for the long-press detector.
  function automatic bit params_legal(input int debounce_cycles,
                                      input int sync_stages,
                                      input int long_press_cycles);
    return (debounce_cycles >= 1) && (sync_stages >= 2) && (long_press_cycles >= 1);
  endfunction

endpackage

// File: rtl/rvx_input_debouncer_channel.sv
// One conditioned input bit: synchroniser, debounce counter, edge pulses
// and (with RVX_INPUT_DEBOUNCER_LONG_PRESS_EN defined) a long-press
// detector. Without the macro, long_press is a constant 0.
module rvx_input_debouncer_channel
  import rvx_input_debouncer_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int   SYNC_STAGES       = DEFAULT_SYNC_STAGES,
  parameter int   LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter logic RESET_VALUE       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic s_in,
  output logic debounced,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic long_press
);

  localparam int               CNT_W    = counter_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (!params_legal(DEBOUNCE_CYCLES, SYNC_STAGES, LONG_PRESS_CYCLES)) begin : g_bad_params
    $error("rvx_input_debouncer_channel: illegal DEBOUNCE_CYCLES/SYNC_STAGES/LONG_PRESS_CYCLES");
  end

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync;
  logic [CNT_W-1:0]       count;

  assign sync = sync_pipe[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the asynchronous pad, last stage is safe to use.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_pipe <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], s_in};
    end
  end

  // Debounce filter: count consecutive mismatching samples; any agreeing sample restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      debounced  <= RESET_VALUE;
      count      <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (sync == debounced) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        debounced  <= sync;
        count      <= '0;
        rise_pulse <= sync;
        fall_pulse <= ~sync;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

`ifdef RVX_INPUT_DEBOUNCER_LONG_PRESS_EN
  localparam int                HOLD_W    = counter_width(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold;

  // Hold timer: runs while pressed, saturates, and fires once when it reaches the limit.
  always_ff @(posedge clock) begin
    if (reset || !debounced) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (hold != HOLD_LAST) begin
        hold       <= hold + HOLD_W'(1);
        long_press <= (hold == HOLD_PRE);
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/rvx_input_debouncer.sv
// Multi-channel input conditioner for RVX board tops. Applies per-channel
// polarity inversion and packs NUM_CHANNELS independent channel filters.
// Optional long-press detection is enabled by defining
// RVX_INPUT_DEBOUNCER_LONG_PRESS_EN; the port list does not change.
module rvx_input_debouncer
  import rvx_input_debouncer_pkg::*;
#(
  parameter int                      NUM_CHANNELS      = 4,
  parameter int                      DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int                      SYNC_STAGES       = DEFAULT_SYNC_STAGES,
  parameter logic [NUM_CHANNELS-1:0] INVERT_MASK       = {NUM_CHANNELS{1'b0}},
  parameter logic [NUM_CHANNELS-1:0] RESET_VALUE       = {NUM_CHANNELS{1'b0}},
  parameter int                      LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] raw_input,
  output logic [NUM_CHANNELS-1:0] debounced,
  output logic [NUM_CHANNELS-1:0] rise_pulse,
  output logic [NUM_CHANNELS-1:0] fall_pulse,
  output logic [NUM_CHANNELS-1:0] long_press
);

  if (NUM_CHANNELS < 1) begin : g_bad_channels
    $error("rvx_input_debouncer: NUM_CHANNELS must be at least 1");
  end

  // Active-low pads are flipped before synchronising so every channel is active-high inside.
  logic [NUM_CHANNELS-1:0] s_in;
  assign s_in = raw_input ^ INVERT_MASK;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    rvx_input_debouncer_channel #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .SYNC_STAGES       (SYNC_STAGES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .RESET_VALUE       (RESET_VALUE[i])
    ) u_channel (
      .clock      (clock),
      .reset      (reset),
      .s_in       (s_in[i]),
      .debounced  (debounced[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i]),
      .long_press (long_press[i])
    );
  end

endmodule

// File: tb/tb_rvx_input_debouncer.sv
// Self-checking bench for rvx_input_debouncer (4 channels, 8-cycle debounce,
// 2-stage synchroniser, 20-cycle long press, INVERT_MASK=1000, RESET_VALUE=0001).
// Honours RVX_INPUT_DEBOUNCER_LONG_PRESS_EN when defined on the command line.
module tb_rvx_input_debouncer;

  localparam int         NCH = 4;
  localparam int         DEB = 8;
  localparam int         SYN = 2;
  localparam int         LP  = 20;
  localparam logic [3:0] INV = 4'b1000;
  localparam logic [3:0] RV  = 4'b0001;

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic [3:0] raw_input = 4'b1001;
  logic [3:0] debounced, rise_pulse, fall_pulse, long_press;

  int compared   = 0;
  int mismatched = 0;

  rvx_input_debouncer #(
    .NUM_CHANNELS      (NCH),
    .DEBOUNCE_CYCLES   (DEB),
    .SYNC_STAGES       (SYN),
    .INVERT_MASK       (INV),
    .RESET_VALUE       (RV),
    .LONG_PRESS_CYCLES (LP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .raw_input  (raw_input),
    .debounced  (debounced),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .long_press (long_press)
  );

  always #5 clock = ~clock;

  // Reference model: synchroniser as a pure sample delay, the filter as
  // "output flips when the last DEB synchronised samples all disagree with it",
  // long press as "exactly LP edges since the output became 1".
  bit [3:0] m_deb, m_rise, m_fall, m_long;
  bit       m_pipe [NCH][SYN];
  bit       m_win  [NCH][DEB];
  int       m_start[NCH];
  int       edge_n = 0;

  task automatic model_edge(input bit rst, input bit [3:0] s);
    bit old_deb, sy, all_diff;
    edge_n++;
    for (int c = 0; c < NCH; c++) begin
      old_deb   = m_deb[c];
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      m_long[c] = 1'b0;
      if (rst) begin
        for (int k = 0; k < SYN; k++) m_pipe[c][k] = RV[c];
        for (int k = 0; k < DEB; k++) m_win[c][k]  = RV[c];
        m_deb[c]   = RV[c];
        m_start[c] = edge_n;
      end else begin
        sy = m_pipe[c][SYN-1];
        for (int k = SYN-1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
        m_pipe[c][0] = s[c];
        for (int k = DEB-1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
        m_win[c][0] = sy;
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (m_win[c][k] == old_deb) all_diff = 1'b0;
`ifdef RVX_INPUT_DEBOUNCER_LONG_PRESS_EN
        if (old_deb && (edge_n - m_start[c] == LP)) m_long[c] = 1'b1;
`endif
        if (all_diff) begin
          m_deb[c]  = ~old_deb;
          m_rise[c] = ~old_deb;
          m_fall[c] = old_deb;
          if (!old_deb) m_start[c] = edge_n;
        end
      end
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs the DUT saw, then compare.
  task automatic tick();
    @(posedge clock);
    model_edge(reset, raw_input ^ INV);
    #1;
    check4($sformatf("deb@%0d", edge_n),  debounced,  m_deb);
    check4($sformatf("rise@%0d", edge_n), rise_pulse, m_rise);
    check4($sformatf("fall@%0d", edge_n), fall_pulse, m_fall);
    check4($sformatf("long@%0d", edge_n), long_press, m_long);
  endtask

  // Edges until any rise/fall pulse appears (including the edge that shows it); -1 on timeout.
  task automatic wait_pulse(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if ((rise_pulse | fall_pulse) != 4'b0000) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic bounce(input int ch, input bit lvl, output int lat, output int npulse);
    bit pat[5];
    pat = '{lvl, !lvl, lvl, lvl, !lvl};
    npulse = 0;
    for (int k = 0; k < 5; k++) begin
      raw_input[ch] = pat[k];
      tick();
      npulse += int'(rise_pulse[ch] | fall_pulse[ch]);
    end
    raw_input[ch] = lvl;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (rise_pulse[ch] | fall_pulse[ch]) begin
        npulse++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  initial begin
    int       n, lat, np, first_long, long_cnt;
    logic [3:0] acc;

    // Reset with inputs matching the reset value.
    repeat (3) tick();
    check4("reset_deb", debounced, 4'b0001);
    check4("reset_pulses", rise_pulse | fall_pulse | long_press, 4'b0000);
    reset = 1'b0;
    acc = 4'b0000;
    repeat (50) begin
      tick();
      acc |= rise_pulse | fall_pulse;
    end
    check4("idle_pulses", acc, 4'b0000);
    check4("idle_deb", debounced, 4'b0001);

    // Clean rising step on channel 1.
    raw_input[1] = 1'b1;
    wait_pulse(n);
    check_int("clean_latency", n, 10);
    check4("clean_rise", rise_pulse, 4'b0010);
    check4("clean_fall", fall_pulse, 4'b0000);
    tick();
    check4("clean_rise_one_cycle", rise_pulse, 4'b0000);
    check4("clean_deb", debounced, 4'b0011);

    // Rising then falling bounce on channel 2.
    bounce(2, 1'b1, lat, np);
    check_int("bounce_rise_latency", lat, 10);
    check_int("bounce_rise_pulses", np, 1);
    check4("bounce_rise_deb", debounced, 4'b0111);
    bounce(2, 1'b0, lat, np);
    check_int("bounce_fall_latency", lat, 10);
    check_int("bounce_fall_pulses", np, 1);
    check4("bounce_fall_deb", debounced, 4'b0011);

    // Active-low channel 3: driving the pad low asserts it.
    raw_input[3] = 1'b0;
    wait_pulse(n);
    check_int("invert_latency", n, 10);
    check4("invert_rise", rise_pulse, 4'b1000);
    tick();
    check4("invert_deb", debounced, 4'b1011);

    // Reset mid-count on channel 0 (counter at 5), then release with inputs off reset value.
    raw_input[0] = 1'b0;
    repeat (7) tick();
    check4("midcount_deb", debounced, 4'b1011);
    reset = 1'b1;
    tick();
    check4("midreset_deb", debounced, 4'b0001);
    check4("midreset_pulses", rise_pulse | fall_pulse, 4'b0000);
    reset = 1'b0;
    wait_pulse(n);
    check_int("post_reset_latency", n, 10);
    check4("post_reset_rise", rise_pulse, 4'b1010);
    check4("post_reset_fall", fall_pulse, 4'b0001);
    tick();
    check4("post_reset_deb", debounced, 4'b1010);

    // Simultaneous opposite steps on channels 0 and 1.
    raw_input[0] = 1'b1;
    raw_input[1] = 1'b0;
    wait_pulse(n);
    check_int("simul_latency", n, 10);
    check4("simul_rise", rise_pulse, 4'b0001);
    check4("simul_fall", fall_pulse, 4'b0010);

    // Hold channel 0 for 40 cycles after its rise.
    first_long = -1;
    long_cnt   = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (long_press[0]) begin
        long_cnt++;
        if (first_long < 0) first_long = k;
      end
    end
`ifdef RVX_INPUT_DEBOUNCER_LONG_PRESS_EN
    check_int("long_press_count", long_cnt, 1);
    check_int("long_press_offset", first_long, LP);
`else
    check_int("long_press_count", long_cnt, 0);
    check_int("long_press_offset", first_long, -1);
`endif

    // Randomised pad activity with occasional resets, checked edge by edge.
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 15) == 0) raw_input[c] = ~raw_input[c];
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rvx_input_debouncer.md
Name: rvx_input_debouncer

Overview:
- Multi-channel conditioner for raw board inputs (push-buttons, switches, external reset buttons) on RVX board tops.
- Per channel: metastability synchroniser, debounce counter and one-cycle edge pulses.
- Replaces single-flop input registration with a configurable, verifiable block.
- Its `debounced` outputs drive `reset_n` and `gpio_input` of `rvx_ocelot`.

Parameters:
- NUM_CHANNELS, 4, number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 120000, consecutive stable clock cycles required before an output changes (>=1). Default is 10 ms at 12 MHz.
- SYNC_STAGES, 2, synchroniser flop depth (>=2).
- INVERT_MASK, {NUM_CHANNELS{1'b0}}, per-channel bit; 1 = input is active-low, inverted before the synchroniser.
- RESET_VALUE, {NUM_CHANNELS{1'b0}}, per-channel value loaded into the synchroniser and `debounced` during reset.
- LONG_PRESS_CYCLES, 1200000, hold time for the long-press detector. Used only with the optional feature.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- raw_input  input  NUM_CHANNELS  asynchronous pad inputs.
- debounced  output  NUM_CHANNELS  stable filtered level per channel.
- rise_pulse  output  NUM_CHANNELS  one-cycle pulse when `debounced` goes 0->1.
- fall_pulse  output  NUM_CHANNELS  one-cycle pulse when `debounced` goes 1->0.
- long_press  output  NUM_CHANNELS  one-cycle long-press pulse; tied 0 without the optional feature.

Behaviour:
- Single clock domain. Reset is sampled only on the rising edge of `clock` while `reset`=1 (synchronous, active-high); there is no asynchronous reset path.
- Reset state:
  - all synchroniser stages of channel i = RESET_VALUE[i];
  - debounced[i] = RESET_VALUE[i];
  - counters = 0;
  - rise_pulse, fall_pulse and long_press = 0.
- Input path: s_in[i] = raw_input[i] ^ INVERT_MASK[i], shifted through SYNC_STAGES flops. `sync[i]` is the last stage.
- Per channel, per clock edge (no reset):
  - sync == debounced: counter <= 0, pulses 0.
  - sync != debounced and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync != debounced and counter == DEBOUNCE_CYCLES-1:
    - debounced <= sync;
    - counter <= 0;
    - rise_pulse or fall_pulse (matching the direction) <= 1 for exactly that one following cycle.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Latency: a clean change captured at edge k appears on `debounced` after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges. Pulses are coincident with the `debounced` change.
- Bounce: any single sample equal to `debounced` clears the counter; the filter restarts from 0.
- DEBOUNCE_CYCLES=1: the output follows `sync` one edge after a mismatch. Pulses still occur.
- Channels are fully independent. Simultaneous transitions on any subset produce simultaneous pulses.
- Reset asserted mid-count: counter discarded; outputs return to RESET_VALUE with no pulse.
- After reset release with the raw level != RESET_VALUE: a normal debounce runs and a pulse fires after the full latency.
- rise_pulse and fall_pulse are never both high on the same channel in the same cycle.

Optional Feature:
- Macro: RVX_INPUT_DEBOUNCER_LONG_PRESS_EN.
- Defined:
  - each channel adds a hold counter of width $clog2(LONG_PRESS_CYCLES+1);
  - the counter clears whenever debounced==0 or on reset, and increments while debounced==1, saturating at LONG_PRESS_CYCLES;
  - long_press[i] pulses for one cycle on the edge the counter reaches LONG_PRESS_CYCLES;
  - exactly one pulse per press; release and re-press re-arms.
- Undefined: no hold counter logic; long_press = 0 constant. The port list is unchanged.

Decomposition:
- Package rvx_input_debouncer_pkg holds:
  - the counter-width helper (clog2 of value+1);
  - default constants DEFAULT_DEBOUNCE_CYCLES and DEFAULT_SYNC_STAGES;
  - parameter-legality checks (DEBOUNCE_CYCLES>=1, SYNC_STAGES>=2, LONG_PRESS_CYCLES>=1).
- Sub-module rvx_input_debouncer_channel:
  - one bit of synchroniser, debounce counter, pulse logic and the optional hold counter;
  - the top instantiates NUM_CHANNELS copies in a generate loop and handles only inversion and bus packing.

Test Plan (NUM_CHANNELS=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2, LONG_PRESS_CYCLES=20 unless stated):
- Reset with RESET_VALUE=4'b0001, raw_input=4'b0001 held -> debounced=4'b0001, no pulses for 50 cycles after reset deasserts.
- Clean step raw_input[1] 0->1 captured at edge k -> debounced[1]=1 after edge k+9; rise_pulse[1]=1 for exactly that cycle; other channels quiet.
- Bounce: raw_input[2] toggles 1,0,1,1,0 then holds 1 -> debounced[2] changes only 10 edges after the final 0->1, with one rise_pulse; same for a falling bounce with fall_pulse.
- INVERT_MASK=4'b1000, raw_input[3] driven 0 -> debounced[3]=1 after 10 edges, rise_pulse[3] once. Simultaneous channel 0/1 steps give coincident pulses.
- reset asserted at counter=5 on channel 0 -> debounced[0] returns to RESET_VALUE[0], no pulse, counter 0. With raw still different after release, the pulse follows 10 edges later.
- With RVX_INPUT_DEBOUNCER_LONG_PRESS_EN, channel 0 held pressed for 40 cycles after debounce -> one long_press[0] pulse 20 edges after the rise. Without the macro -> long_press==0 throughout.
